// File: rtl/f1_pkg.sv
// f1_pkg: shared types and helpers for the F1 reaction-time controller.
//   state_t    - sequencer states
//   lfsr_taps  - Fibonacci LFSR feedback mask for a given register width
//   best_init  - all-ones value of a given width (best-time reset/clear value)
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        HOLD,
        GO,
        DONE,
        FAULT
    } state_t;

    // Tap n (1-based) maps to mask bit n-1. Widths outside the table fall
    // back to the 14-bit polynomial.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       lfsr_taps = 32'h0000_00B8;  // taps 8,6,5,4
            16:      lfsr_taps = 32'h0000_D008;  // taps 16,15,13,4
            default: lfsr_taps = 32'h0000_3802;  // taps 14,13,12,2
        endcase
    endfunction

    function automatic logic [31:0] best_init(input int w);
        if (w >= 32) begin
            best_init = '1;
        end else begin
            best_init = (32'd1 << w) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/f1_reaction_ctrl_lfsr_gen.sv
// lfsr_gen: free-running Fibonacci LFSR, seeded with 1 on reset.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - advance enable
//   q          - current register value (never all-zero)
module lfsr_gen
    import f1_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[W-2:0], ^(q_q & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= W'(1);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/f1_reaction_ctrl.sv
// f1_reaction_ctrl: F1 start-light sequencer with reaction-time measurement.
// Lights the lamps one per STEP_MS ticks, holds them for a random delay,
// extinguishes them ("go") and times the driver's button press in ms.
//   clk, rst_n   - clock, asynchronous active-low reset
//   tick_ms      - one-clk 1 ms enable; all timers advance only on it
//   trigger      - start request (rising edge)
//   react        - driver button (rising edge)
//   clr_best     - clear best_ms to all-ones
//   lights       - lamp drive, bit i = lamp i
//   go / false_start - high in GO / FAULT
//   result_valid - one-clk pulse when react_ms updates
//   timeout      - last result saturated
//   react_ms / best_ms / delay_ms - last, best and captured hold times
module f1_reaction_ctrl
    import f1_pkg::*;
#(
    parameter int NUM_LIGHTS   = 10,
    parameter int STEP_MS      = 500,
    parameter int LFSR_W       = 14,
    parameter int DLY_W        = 12,
    parameter int DELAY_MIN_MS = 200,
    parameter int CNT_W        = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_ms,
    input  logic                  trigger,
    input  logic                  react,
    input  logic                  clr_best,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  go,
    output logic                  false_start,
    output logic                  result_valid,
    output logic                  timeout,
    output logic [CNT_W-1:0]      react_ms,
    output logic [CNT_W-1:0]      best_ms,
    output logic [DLY_W:0]        delay_ms
);

    localparam int DW     = DLY_W + 1;
    localparam int STEP_W = $clog2(STEP_MS + 1);

    localparam logic [CNT_W-1:0]  BEST_INIT = CNT_W'(best_init(CNT_W));
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MS - 1);
    localparam logic [DW-1:0]     DLY_MIN   = DW'(DELAY_MIN_MS);

    state_t                  state_q, state_d;
    logic [NUM_LIGHTS-1:0]   lights_q, lights_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [DW-1:0]           hold_q, hold_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        react_ms_q, react_ms_d;
    logic [CNT_W-1:0]        best_q, best_d;
    logic [DW-1:0]           delay_q, delay_d;
    logic                    timeout_q, timeout_d;
    logic                    rv_q, rv_d;
    logic                    trig_prev_q, react_prev_q;

    logic [LFSR_W-1:0]       lfsr_q;
    logic [DW-1:0]           dly_new;
    logic [NUM_LIGHTS-1:0]   lights_next;
    logic                    trig_edge, react_edge;

    lfsr_gen #(.W(LFSR_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    // Only the low DLY_W bits feed the delay; the rest just keep the
    // sequence long.
    if (DLY_W < LFSR_W) begin : g_lfsr_hi
        logic unused_lfsr_hi;
        assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:DLY_W];
    end

    assign trig_edge   = trigger & ~trig_prev_q;
    assign react_edge  = react & ~react_prev_q;
    assign dly_new     = DLY_MIN + DW'(lfsr_q[DLY_W-1:0]);
    // Lamps light in index order, so the lamp pattern is a thermometer code.
    assign lights_next = (lights_q << 1) | NUM_LIGHTS'(1);

    always_comb begin
        state_d    = state_q;
        lights_d   = lights_q;
        step_d     = step_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        react_ms_d = react_ms_q;
        best_d     = best_q;
        delay_d    = delay_q;
        timeout_d  = timeout_q;
        rv_d       = 1'b0;

        case (state_q)
            IDLE, DONE, FAULT: begin
                if (trig_edge) begin
                    state_d   = ARM;
                    lights_d  = '0;
                    step_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ARM: begin
                if (react_edge) begin
                    state_d  = FAULT;
                    lights_d = '1;
                end else if (tick_ms) begin
                    if (step_q == STEP_LAST) begin
                        step_d   = '0;
                        lights_d = lights_next;
                        if (&lights_next) begin
                            state_d = HOLD;
                            delay_d = dly_new;
                            hold_d  = dly_new;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            HOLD: begin
                // A press on the expiry tick is still a false start.
                if (react_edge) begin
                    state_d  = FAULT;
                    lights_d = '1;
                end else if (tick_ms) begin
                    hold_d = hold_q - DW'(1);
                    if (hold_q <= DW'(1)) begin
                        state_d  = GO;
                        lights_d = '0;
                        cnt_d    = '0;
                    end
                end
            end
            GO: begin
                // A press on the saturating tick is a valid result.
                if (react_edge) begin
                    state_d    = DONE;
                    react_ms_d = cnt_q;
                    rv_d       = 1'b1;
                    timeout_d  = 1'b0;
                    if (cnt_q < best_q) begin
                        best_d = cnt_q;
                    end
                end else if (tick_ms) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == (BEST_INIT - CNT_W'(1))) begin
                        state_d    = DONE;
                        react_ms_d = BEST_INIT;
                        rv_d       = 1'b1;
                        timeout_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_best) begin
            best_d = BEST_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lights_q     <= '0;
            step_q       <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            react_ms_q   <= '0;
            best_q       <= BEST_INIT;
            delay_q      <= '0;
            timeout_q    <= 1'b0;
            rv_q         <= 1'b0;
            trig_prev_q  <= 1'b0;
            react_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lights_q     <= lights_d;
            step_q       <= step_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            react_ms_q   <= react_ms_d;
            best_q       <= best_d;
            delay_q      <= delay_d;
            timeout_q    <= timeout_d;
            rv_q         <= rv_d;
            trig_prev_q  <= trigger;
            react_prev_q <= react;
        end
    end

    assign lights       = lights_q;
    assign go           = (state_q == GO);
    assign false_start  = (state_q == FAULT);
    assign result_valid = rv_q;
    assign timeout      = timeout_q;
    assign react_ms     = react_ms_q;
    assign best_ms      = best_q;
    assign delay_ms     = delay_q;

endmodule
